mc_main_fsm: RTL
================

// Module: mc_main_fsm
// PURPOSE
//  Main control FSM of the multicycle ARM core. Sequences the shared datapath (IR, PC, A/B regs,
//  ALU, ALUOut, Data reg, single memory port) over FETCH/DECODE/EXECUTE/MEM/WB steps.
//  Driven by Op/Funct from the instruction register. Outputs are Moore-decoded from state.
//  RegW/MemW/Branch are raw requests; the downstream condition logic gates them with Cond/flags.
// PARAMETERS
//  STATE_W  4  state register width (11 states used; codes 11..15 are illegal)
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high reset
//  Op         in   2  Instr[27:26]: 00 data-proc, 01 mem, 10 branch, 11 undefined
//  Funct      in   6  Instr[25:20]: [5]=I (immediate), [0]=L (load) / S
//  MemReady   in   1  memory access complete; used only with MC_MEM_WAIT_EN
//  IRWrite    out  1  load IR from memory read data
//  NextPC     out  1  load PC with Result (PC+4)
//  AdrSrc     out  1  mem addr: 0=PC, 1=Result/ALUOut
//  ALUSrcA    out  1  0=A reg, 1=PC
//  ALUSrcB    out  2  00=WriteData(B), 01=ExtImm, 10=const 4, 11=unused
//  ResultSrc  out  2  00=ALUOut, 01=Data reg, 10=ALUResult
//  ALUOp      out  1  1=ALU decoder uses Funct; 0=force ADD
//  RegW       out  1  register-file write request
//  MemW       out  1  memory write request
//  Branch     out  1  branch request (PC <- ALUResult if cond passes)
//  State      out  4  current state code (debug/trace)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECUTER=6 EXECUTEI=7 ALUWB=8
//   BRANCH=9 UNKNOWN=10. reset -> FETCH asynchronously; all outputs = FETCH decode below.
//  Transitions (one per clk): FETCH->DECODE. DECODE: Op=01->MEMADR; Op=00&Funct[5]->EXECUTEI;
//   Op=00&!Funct[5]->EXECUTER; Op=10->BRANCH; Op=11->UNKNOWN. MEMADR: Funct[0]->MEMRD else MEMWR.
//   MEMRD->MEMWB->FETCH. MEMWR->FETCH. EXECUTER/EXECUTEI->ALUWB->FETCH. BRANCH, UNKNOWN->FETCH.
//   Illegal code 11..15 -> FETCH next cycle, outputs all 0 while there.
//  Outputs (unlisted = 0):
//   FETCH:    IRWrite=1 NextPC=1 AdrSrc=0 ALUSrcA=1 ALUSrcB=10 ResultSrc=10
//   DECODE:   ALUSrcA=1 ALUSrcB=10 ResultSrc=10 (forms PC+8 for R15 reads)
//   MEMADR:   ALUSrcA=0 ALUSrcB=01
//   MEMRD:    AdrSrc=1 ResultSrc=00
//   MEMWB:    ResultSrc=01 RegW=1
//   MEMWR:    AdrSrc=1 ResultSrc=00 MemW=1
//   EXECUTER: ALUSrcA=0 ALUSrcB=00 ALUOp=1
//   EXECUTEI: ALUSrcA=0 ALUSrcB=01 ALUOp=1
//   ALUWB:    ResultSrc=00 RegW=1
//   BRANCH:   ALUSrcA=0 ALUSrcB=01 ResultSrc=10 Branch=1
//   UNKNOWN:  all 0 (instruction treated as NOP)
//  Latency: LDR 5 cycles, STR 4, data-proc 4, branch 3, undefined 3 (MEM_WAIT off).
//  Op/Funct sampled only in DECODE/MEMADR; IR stable after FETCH, so no extra input latching.
//  Reset mid-instruction: aborts; no RegW/MemW pulse after reset deasserts until re-fetched.
// CONFIGURATION
//  MC_MEM_WAIT_EN defined: FETCH, MEMRD, MEMWR hold while MemReady=0.
//   Held FETCH: IRWrite=NextPC=0. Held MEMWR: MemW=1 stays asserted.
//   Advance/strobe only in a cycle with MemReady=1.
//  Undefined: MemReady ignored; every state lasts exactly one cycle.
// TESTING
//  Reset mid-MEMWR -> State=0, IRWrite=1, NextPC=1, MemW=0 immediately (async, no clk edge).
//  ADD reg (Op=00,Funct=001000) -> states 0,1,6,8,0; ALUOp=1 in 6; RegW=1 only in 8.
//  LDR (Op=01,Funct=011001) -> 0,1,2,3,4,0; AdrSrc=1 in 3; ResultSrc=01 and RegW=1 in 4.
//  STR (Op=01,Funct=011000) -> 0,1,2,5,0; MemW=1 for exactly 1 cycle; RegW never set.
//  B (Op=10) -> 0,1,9,0 with Branch=1 in 9. Op=11 -> 0,1,10,0 with all strobes 0.
//  MC_MEM_WAIT_EN: MemReady=0 for 3 cycles in FETCH -> State=0 for 4 cycles; IRWrite=1 only in last.

Source files
------------

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle ARM core: Moore-decoded datapath controls per step.
// Optional MC_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until MemReady=1.
module mc_main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic [STATE_W-1:0] State
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(4'd0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(4'd1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(4'd2);
    localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(4'd3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4'd4);
    localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(4'd5);
    localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(4'd6);
    localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(4'd7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(4'd8);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(4'd9);
    localparam logic [STATE_W-1:0] S_UNKNOWN  = STATE_W'(4'd10);

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] next_state_s;
    logic               mem_go_s;

`ifdef MC_MEM_WAIT_EN
    assign mem_go_s = MemReady;
`else
    logic mem_ready_unused_s;
    assign mem_ready_unused_s = MemReady;
    assign mem_go_s           = 1'b1;
`endif

    assign State = state_r;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state sequencing from Op/Funct (IR is stable after FETCH)
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_state_s = mem_go_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   next_state_s = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   next_state_s = S_MEMADR;
                    2'b10:   next_state_s = S_BRANCH;
                    default: next_state_s = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   next_state_s = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    next_state_s = mem_go_s ? S_MEMWB : S_MEMRD;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWR:    next_state_s = mem_go_s ? S_FETCH : S_MEMWR;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BRANCH:   next_state_s = S_FETCH;
            S_UNKNOWN:  next_state_s = S_FETCH;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Moore output decode; illegal codes drive everything low
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        case (state_r)
            S_FETCH: begin
                IRWrite   = mem_go_s;
                NextPC    = mem_go_s;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: begin
                ALUOp = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB: begin
                RegW = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            S_UNKNOWN: begin
                IRWrite = 1'b0;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

endmodule
